// File: rtl/fe_req_arbiter.sv
// Round-robin arbiter sharing the front-end Avalon data channel between
// peripheral front-end devices; the FE writes data that is strobed to the granted device.
module fe_req_arbiter #(
  parameter int NDEV = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NDEV-1:0] dev_rq,
  output logic [NDEV-1:0] dev_write,
  output logic [31:0]     dev_writedata,
  input  logic            s_address,
  input  logic            s_read,
  output logic [31:0]     s_readdata,
  input  logic            s_write,
  input  logic [31:0]     s_writedata,
  output logic            fe_irq
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  localparam logic [2:0] LAST_DEV = 3'(NDEV - 1);

  state_t     state;
  logic [2:0] rr_ptr;
  logic [2:0] grant;
  logic       err;

  logic [7:0] rq8;
  logic [7:0] grant_onehot;
  logic [2:0] pick;
  logic [2:0] grant_inc;
  logic       any_rq;
  logic       rq_granted;
  logic       data_wr;
  logic       ctrl_wr;

  always_comb begin
    rq8 = '0;
    rq8[NDEV-1:0] = dev_rq;
  end

  // First requester at or after rr_ptr, wrapping at NDEV-1 -> 0.
  always_comb begin
    int unsigned idx;
    any_rq = 1'b0;
    pick   = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NDEV) idx = idx - NDEV;
      if (!any_rq && rq8[idx[2:0]]) begin
        any_rq = 1'b1;
        pick   = idx[2:0];
      end
    end
  end

  assign grant_inc    = (grant == LAST_DEV) ? 3'd0 : grant + 3'd1;
  assign grant_onehot = 8'b1 << grant;
  assign rq_granted   = rq8[grant];
  assign data_wr      = s_write && s_address;
  assign ctrl_wr      = s_write && !s_address;

  always_comb begin
    s_readdata = '0;
    if (s_read && !s_address)
      s_readdata = {(state == GRANT), 7'b0, rq8, 7'b0, err, 5'b0, grant};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      err           <= 1'b0;
      dev_write     <= '0;
      dev_writedata <= '0;
      fe_irq        <= 1'b0;
    end else begin
      dev_write <= '0;
      // Clear first so a stray write in the same cycle still leaves err set.
      if (ctrl_wr && s_writedata[8]) err <= 1'b0;
      case (state)
        IDLE: begin
          if (data_wr) err <= 1'b1;
          if (any_rq) begin
            grant  <= pick;
            state  <= GRANT;
            fe_irq <= 1'b1;
          end
        end
        GRANT: begin
          if (!rq_granted) begin
            if (data_wr) err <= 1'b1;
            rr_ptr <= grant_inc;
            state  <= IDLE;
            fe_irq <= 1'b0;
          end else if (data_wr) begin
            dev_writedata <= s_writedata;
            dev_write     <= grant_onehot[NDEV-1:0];
            rr_ptr        <= grant_inc;
            state         <= RELEASE;
            fe_irq        <= 1'b0;
          end
        end
        RELEASE: begin
          if (data_wr) err <= 1'b1;
          if (!rq_granted) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          fe_irq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fe_req_arbiter.sv
// Directed self-checking bench for fe_req_arbiter (NDEV = 4).
module tb_fe_req_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  dev_rq;
  logic [3:0]  dev_write;
  logic [31:0] dev_writedata;
  logic        s_address;
  logic        s_read;
  logic [31:0] s_readdata;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        fe_irq;

  int tests;
  int fails;

  fe_req_arbiter #(.NDEV(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .dev_rq        (dev_rq),
    .dev_write     (dev_write),
    .dev_writedata (dev_writedata),
    .s_address     (s_address),
    .s_read        (s_read),
    .s_readdata    (s_readdata),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .fe_irq        (fe_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_status(output logic [31:0] d);
    s_address = 1'b0;
    s_read    = 1'b1;
    #1;
    d      = s_readdata;
    s_read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] st;
    reset = 1'b0;
    dev_rq = '0;
    #3;
    tests++;
    if (fe_irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b exp 0", fe_irq); end
    tests++;
    if (dev_write !== 4'b0) begin fails++; $display("FAIL reset_dev_write got %b exp 0000", dev_write); end
    tests++;
    if (dev_writedata !== 32'h0) begin fails++; $display("FAIL reset_writedata got %h exp 00000000", dev_writedata); end
    read_status(st);
    tests++;
    if (st !== 32'h0) begin fails++; $display("FAIL reset_status got %h exp 00000000", st); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [31:0] st;
    dev_rq = 4'b0100;
    step();
    tests++;
    if (fe_irq !== 1'b1) begin fails++; $display("FAIL single_irq got %b exp 1", fe_irq); end
    read_status(st);
    tests++;
    if (st !== 32'h8004_0002) begin fails++; $display("FAIL single_status got %h exp 80040002", st); end
    s_address = 1'b1; s_write = 1'b1; s_writedata = 32'h0000_00A5;
    step();
    s_write = 1'b0;
    tests++;
    if (dev_write !== 4'b0100) begin fails++; $display("FAIL single_strobe got %b exp 0100", dev_write); end
    tests++;
    if (dev_writedata !== 32'hA5) begin fails++; $display("FAIL single_data got %h exp 000000a5", dev_writedata); end
    tests++;
    if (fe_irq !== 1'b0) begin fails++; $display("FAIL single_irq_fall got %b exp 0", fe_irq); end
    step();
    tests++;
    if (dev_write !== 4'b0) begin fails++; $display("FAIL single_strobe_end got %b exp 0000", dev_write); end
    dev_rq = 4'b0000;
    step();
    read_status(st);
    tests++;
    if (st !== 32'h0000_0002) begin fails++; $display("FAIL single_idle_status got %h exp 00000002", st); end
  endtask

  task automatic test_round_robin();
    int exp_order [4] = '{0, 1, 3, 0};
    logic [31:0] st;
    logic [3:0] exp_strobe;
    int c;
    do_reset();
    dev_rq = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      c = 0;
      while (!fe_irq && c < 10) begin step(); c++; end
      tests++;
      if (!fe_irq) begin fails++; $display("FAIL rr_timeout got irq 0 exp 1 (grant %0d)", k); end
      read_status(st);
      tests++;
      if (st[2:0] !== 3'(exp_order[k])) begin
        fails++; $display("FAIL rr_grant%0d got %0d exp %0d", k, st[2:0], exp_order[k]);
      end
      s_address = 1'b1; s_write = 1'b1; s_writedata = 32'h100 + 32'(k);
      step();
      s_write = 1'b0;
      exp_strobe = 4'b0001 << exp_order[k];
      tests++;
      if (dev_write !== exp_strobe) begin fails++; $display("FAIL rr_strobe%0d got %b exp %b", k, dev_write, exp_strobe); end
      step();
      dev_rq[exp_order[k]] = 1'b0;
      step();
      dev_rq[exp_order[k]] = 1'b1;
    end
    dev_rq = 4'b0000;
    step();
    step();
  endtask

  task automatic test_cancel();
    logic [31:0] st;
    do_reset();
    dev_rq = 4'b0010;
    step();
    read_status(st);
    tests++;
    if (st !== 32'h8002_0001) begin fails++; $display("FAIL cancel_grant got %h exp 80020001", st); end
    dev_rq = 4'b0101;
    step();
    tests++;
    if (fe_irq !== 1'b0) begin fails++; $display("FAIL cancel_irq got %b exp 0", fe_irq); end
    tests++;
    if (dev_write !== 4'b0) begin fails++; $display("FAIL cancel_strobe got %b exp 0000", dev_write); end
    step();
    read_status(st);
    tests++;
    if (st !== 32'h8005_0002) begin fails++; $display("FAIL cancel_next got %h exp 80050002", st); end
    dev_rq = 4'b0000;
    step();
    step();
  endtask

  task automatic test_cancel_write();
    logic [31:0] st;
    do_reset();
    dev_rq = 4'b0010;
    step();
    dev_rq = 4'b0000;
    s_address = 1'b1; s_write = 1'b1; s_writedata = 32'h55;
    step();
    s_write = 1'b0;
    tests++;
    if (dev_write !== 4'b0) begin fails++; $display("FAIL cw_strobe got %b exp 0000", dev_write); end
    tests++;
    if (fe_irq !== 1'b0) begin fails++; $display("FAIL cw_irq got %b exp 0", fe_irq); end
    step();
    tests++;
    if (dev_write !== 4'b0) begin fails++; $display("FAIL cw_strobe_late got %b exp 0000", dev_write); end
    read_status(st);
    tests++;
    if (st !== 32'h0000_0101) begin fails++; $display("FAIL cw_err_set got %h exp 00000101", st); end
    s_address = 1'b0; s_write = 1'b1; s_writedata = 32'h100;
    step();
    s_write = 1'b0;
    read_status(st);
    tests++;
    if (st !== 32'h0000_0001) begin fails++; $display("FAIL cw_err_clear got %h exp 00000001", st); end
  endtask

  task automatic test_stray();
    logic [31:0] st;
    s_address = 1'b1; s_write = 1'b1; s_writedata = 32'h77;
    step();
    s_write = 1'b0;
    tests++;
    if (dev_write !== 4'b0) begin fails++; $display("FAIL stray_strobe got %b exp 0000", dev_write); end
    read_status(st);
    tests++;
    if (st !== 32'h0000_0101) begin fails++; $display("FAIL stray_err got %h exp 00000101", st); end
    s_address = 1'b0; s_write = 1'b1; s_writedata = 32'h100;
    step();
    read_status(st);
    tests++;
    if (st !== 32'h0000_0001) begin fails++; $display("FAIL stray_clear got %h exp 00000001", st); end
    s_address = 1'b1; s_writedata = 32'h99;
    step();
    s_write = 1'b0;
    read_status(st);
    tests++;
    if (st !== 32'h0000_0101) begin fails++; $display("FAIL stray_reset_err got %h exp 00000101", st); end
  endtask

  task automatic test_async_reset();
    logic [31:0] st;
    dev_rq = 4'b0001;
    step();
    tests++;
    if (fe_irq !== 1'b1) begin fails++; $display("FAIL ar_irq_pre got %b exp 1", fe_irq); end
    #2;
    reset = 1'b0;
    dev_rq = 4'b0000;
    #1;
    tests++;
    if (fe_irq !== 1'b0) begin fails++; $display("FAIL ar_irq got %b exp 0", fe_irq); end
    read_status(st);
    tests++;
    if (st !== 32'h0) begin fails++; $display("FAIL ar_status got %h exp 00000000", st); end
    reset = 1'b1;
    step();
    dev_rq = 4'b0010;
    step();
    s_address = 1'b1; s_write = 1'b1; s_writedata = 32'hDEAD_BEEF;
    step();
    s_write = 1'b0;
    tests++;
    if (dev_write !== 4'b0010) begin fails++; $display("FAIL ar_strobe_pre got %b exp 0010", dev_write); end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (dev_write !== 4'b0) begin fails++; $display("FAIL ar_strobe got %b exp 0000", dev_write); end
    tests++;
    if (dev_writedata !== 32'h0) begin fails++; $display("FAIL ar_data got %h exp 00000000", dev_writedata); end
    dev_rq = 4'b1100;
    reset = 1'b1;
    step();
    read_status(st);
    tests++;
    if (st !== 32'h800C_0002) begin fails++; $display("FAIL ar_regrant got %h exp 800c0002", st); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    dev_rq = '0;
    s_address = 1'b0;
    s_read = 1'b0;
    s_write = 1'b0;
    s_writedata = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_cancel();
    test_cancel_write();
    test_stray();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
